// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding, requester ids and memory op codes for mem_port_arbiter.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_S_IDLE  = 2'd0,
        ARB_S_ISSUE = 2'd1,
        ARB_S_WAIT  = 2'd2,
        ARB_S_DONE  = 2'd3
    } arb_state_e;

    localparam logic ARB_REQ_CPU = 1'b0;
    localparam logic ARB_REQ_DBG = 1'b1;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Width of the WAIT down-counter; it only ever holds MEM_LAT-2.
    function automatic int unsigned arb_cnt_w(input int unsigned lat);
        return (lat > 32'd2) ? 32'($clog2(lat - 32'd1)) : 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not win last time is chosen.
module mem_port_arbiter_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid_c,
    output logic       o_pick_c
);

    always_comb begin
        o_valid_c = |i_req;
        o_pick_c  = ARB_REQ_CPU;
        if (&i_req) begin
            o_pick_c = ~i_last;
        end else if (i_req[1]) begin
            o_pick_c = ARB_REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the CPU
// sequencer (req 0) and the debug loader (req 1). Define ARB_LOCK_EN for locking.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_rw0,
    input  logic          i_rw1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    input  logic          i_lock0,
    input  logic          i_lock1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata,
    output logic          o_mem_en,
    output logic          o_mem_rw,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int unsigned CW      = arb_cnt_w(MEM_LAT);
    localparam int unsigned WAIT_LD = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
    localparam logic        LAT_ONE = (MEM_LAT == 1);

    arb_state_e    r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_rw, w_rw_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          r_rr_last, w_rr_last_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_load;
    logic          w_pick_valid;
    logic          w_pick;
    logic          w_lock_hold;
    logic          w_busy_nxt;
    logic          w_capture;

    mem_port_arbiter_rr_pick2 u_pick (
        .i_req     ({i_req1, i_req0}),
        .i_last    (r_rr_last),
        .o_valid_c (w_pick_valid),
        .o_pick_c  (w_pick)
    );

`ifdef ARB_LOCK_EN
    assign w_lock_hold = (r_owner == ARB_REQ_DBG) ? (i_lock1 & i_req1)
                                                  : (i_lock0 & i_req0);
`else
    logic w_unused_lock;
    assign w_unused_lock = i_lock0 | i_lock1;
    assign w_lock_hold   = 1'b0;
`endif

    // Next-state and transaction latch selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rw_nxt      = r_rw;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rr_last_nxt = r_rr_last;
        w_cnt_nxt     = r_cnt;
        w_load        = 1'b0;
        case (r_state)
            ARB_S_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt   = ARB_S_ISSUE;
                    w_owner_nxt   = w_pick;
                    w_rr_last_nxt = w_pick;
                    w_load        = 1'b1;
                end
            end
            ARB_S_ISSUE: begin
                if (LAT_ONE) begin
                    w_state_nxt = ARB_S_DONE;
                end else begin
                    w_state_nxt = ARB_S_WAIT;
                    w_cnt_nxt   = CW'(WAIT_LD);
                end
            end
            ARB_S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ARB_S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ARB_S_DONE: begin
                // A locked owner re-issues directly; rr_last is left alone.
                if (w_lock_hold) begin
                    w_state_nxt = ARB_S_ISSUE;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ARB_S_IDLE;
                end
            end
            default: w_state_nxt = ARB_S_IDLE;
        endcase
        if (w_load) begin
            w_rw_nxt    = (w_owner_nxt == ARB_REQ_DBG) ? i_rw1    : i_rw0;
            w_addr_nxt  = (w_owner_nxt == ARB_REQ_DBG) ? i_addr1  : i_addr0;
            w_wdata_nxt = (w_owner_nxt == ARB_REQ_DBG) ? i_wdata1 : i_wdata0;
        end
    end

    assign w_busy_nxt = (w_state_nxt == ARB_S_ISSUE) || (w_state_nxt == ARB_S_WAIT);
    assign w_capture  = (r_rw != MEM_WR) &&
                        (((r_state == ARB_S_ISSUE) && LAT_ONE) ||
                         ((r_state == ARB_S_WAIT) && (r_cnt == '0)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner   <= ARB_REQ_CPU;
            r_rw      <= MEM_RD;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rr_last <= ARB_REQ_DBG;
            r_cnt     <= '0;
        end else begin
            r_owner   <= w_owner_nxt;
            r_rw      <= w_rw_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Outputs are registered from the next-state view so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_ack0      <= 1'b0;
            o_ack1      <= 1'b0;
            o_rdata     <= '0;
            o_mem_en    <= 1'b0;
            o_mem_rw    <= MEM_RD;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_gnt0      <= (w_state_nxt != ARB_S_IDLE) && (w_owner_nxt == ARB_REQ_CPU);
            o_gnt1      <= (w_state_nxt != ARB_S_IDLE) && (w_owner_nxt == ARB_REQ_DBG);
            o_ack0      <= (w_state_nxt == ARB_S_DONE) && (w_owner_nxt == ARB_REQ_CPU);
            o_ack1      <= (w_state_nxt == ARB_S_DONE) && (w_owner_nxt == ARB_REQ_DBG);
            o_mem_en    <= (w_state_nxt == ARB_S_ISSUE);
            o_mem_rw    <= w_busy_nxt ? w_rw_nxt    : MEM_RD;
            o_mem_addr  <= w_busy_nxt ? w_addr_nxt  : '0;
            o_mem_wdata <= w_busy_nxt ? w_wdata_nxt : '0;
            if (w_capture) begin
                o_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios on a MEM_LAT=1 and a
// MEM_LAT=3 instance plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int B_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic          a_req0, a_req1, a_rw0, a_rw1, a_lock0, a_lock1;
    logic [AW-1:0] a_addr0, a_addr1, a_mem_addr;
    logic [DW-1:0] a_wd0, a_wd1, a_rdata, a_mem_wdata, a_mem_rdata;
    logic          a_gnt0, a_gnt1, a_ack0, a_ack1, a_mem_en, a_mem_rw;

    logic          b_req0, b_req1, b_rw0, b_rw1, b_lock0, b_lock1;
    logic [AW-1:0] b_addr0, b_addr1, b_mem_addr;
    logic [DW-1:0] b_wd0, b_wd1, b_rdata, b_mem_wdata, b_mem_rdata;
    logic          b_gnt0, b_gnt1, b_ack0, b_ack1, b_mem_en, b_mem_rw;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(a_req0), .i_req1(a_req1), .i_rw0(a_rw0), .i_rw1(a_rw1),
        .i_addr0(a_addr0), .i_addr1(a_addr1), .i_wdata0(a_wd0), .i_wdata1(a_wd1),
        .i_lock0(a_lock0), .i_lock1(a_lock1),
        .o_gnt0(a_gnt0), .o_gnt1(a_gnt1), .o_ack0(a_ack0), .o_ack1(a_ack1),
        .o_rdata(a_rdata), .o_mem_en(a_mem_en), .o_mem_rw(a_mem_rw),
        .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(B_LAT)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(b_req0), .i_req1(b_req1), .i_rw0(b_rw0), .i_rw1(b_rw1),
        .i_addr0(b_addr0), .i_addr1(b_addr1), .i_wdata0(b_wd0), .i_wdata1(b_wd1),
        .i_lock0(b_lock0), .i_lock1(b_lock1),
        .o_gnt0(b_gnt0), .o_gnt1(b_gnt1), .o_ack0(b_ack0), .o_ack1(b_ack1),
        .o_rdata(b_rdata), .o_mem_en(b_mem_en), .o_mem_rw(b_mem_rw),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata)
    );

    // Memory arrays behind each port; read data is only valid at the latency point.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       pl_we = 1'b0;
    logic       pl_sel = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;
    int         b_lat_cnt;

    always @(posedge clk) begin
        if (a_mem_en && a_mem_rw) mem_a[a_mem_addr] <= a_mem_wdata;
        else if (pl_we && !pl_sel) mem_a[pl_addr] <= pl_data;
        if (b_mem_en && b_mem_rw) mem_b[b_mem_addr] <= b_mem_wdata;
        else if (pl_we && pl_sel) mem_b[pl_addr] <= pl_data;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_lat_cnt <= 0;
        else if (b_mem_en) b_lat_cnt <= 1;
        else if (b_lat_cnt != 0 && b_lat_cnt < B_LAT - 1) b_lat_cnt <= b_lat_cnt + 1;
        else b_lat_cnt <= 0;
    end

    assign a_mem_rdata = a_mem_en ? mem_a[a_mem_addr] : 8'hEE;
    assign b_mem_rdata = (b_lat_cnt == B_LAT - 1) ? mem_b[b_mem_addr] : 8'hEE;

    task automatic clear_inputs();
        {a_req0, a_req1, a_rw0, a_rw1, a_lock0, a_lock1} = '0;
        {a_addr0, a_addr1, a_wd0, a_wd1} = '0;
        {b_req0, b_req1, b_rw0, b_rw1, b_lock0, b_lock1} = '0;
        {b_addr0, b_addr1, b_wd0, b_wd1} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic sel, input logic [7:0] a, input logic [7:0] d);
        pl_sel = sel; pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_gnt0, a_gnt1, a_ack0, a_ack1, a_mem_en, a_mem_rw, a_mem_addr, a_mem_wdata, a_rdata} !== '0) begin
            errors++; $display("FAIL reset_a outputs gnt%b%b ack%b%b en%b rdata %h", a_gnt0, a_gnt1, a_ack0, a_ack1, a_mem_en, a_rdata);
        end
        checks++;
        if ({b_gnt0, b_gnt1, b_ack0, b_ack1, b_mem_en, b_mem_rw, b_mem_addr, b_mem_wdata, b_rdata} !== '0) begin
            errors++; $display("FAIL reset_b outputs gnt%b%b ack%b%b en%b rdata %h", b_gnt0, b_gnt1, b_ack0, b_ack1, b_mem_en, b_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cpu_read();
        preload(1'b0, 8'h10, 8'hA5);
        a_req0 = 1'b1; a_rw0 = 1'b0; a_addr0 = 8'h10;
        @(negedge clk);
        checks++;
        if ({a_mem_en, a_mem_rw, a_mem_addr, a_gnt0, a_gnt1, a_ack0} !== {1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL cpu_read_issue en %b rw %b addr %h gnt %b%b ack0 %b exp en1 rw0 addr 10 gnt0", a_mem_en, a_mem_rw, a_mem_addr, a_gnt0, a_gnt1, a_ack0);
        end
        @(negedge clk);
        checks++;
        if ({a_mem_en, a_ack0, a_gnt0, a_gnt1} !== 4'b0110) begin
            errors++; $display("FAIL cpu_read_done en %b ack0 %b gnt %b%b exp en0 ack1 gnt0", a_mem_en, a_ack0, a_gnt0, a_gnt1);
        end
        checks++;
        if (a_rdata !== 8'hA5) begin
            errors++; $display("FAIL cpu_read_data got %h exp a5", a_rdata);
        end
        a_req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ack0, a_gnt0, a_gnt1} !== 3'b000) begin
            errors++; $display("FAIL cpu_read_after ack0 %b gnt %b%b exp 0", a_ack0, a_gnt0, a_gnt1);
        end
    endtask

    task automatic test_alternate();
        logic exp_own [4];
        logic got_own [4];
        int   got_cyc [4];
        int   n = 0;
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        a_req0 = 1'b1; a_req1 = 1'b1; a_addr0 = 8'h10; a_addr1 = 8'h10;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            @(negedge clk);
            if (a_gnt0 && a_gnt1) begin
                checks++; errors++; $display("FAIL alt_gnt_both cycle %0d", c);
            end
            if (a_mem_en) begin
                got_own[n] = a_gnt1; got_cyc[n] = c; n++;
            end
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL alt_count got %0d exp 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_own[i] !== exp_own[i]) begin
                    errors++; $display("FAIL alt_owner txn %0d got %b exp %b", i, got_own[i], exp_own[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] != 3) begin
                    errors++; $display("FAIL alt_spacing txn %0d got %0d exp 3", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        // Request dropped during ISSUE: transaction still completes.
        @(negedge clk);
        checks++;
        if (a_ack1 !== 1'b1) begin
            errors++; $display("FAIL alt_drop_ack got %b exp 1", a_ack1);
        end
        checks++;
        if (a_rdata !== 8'hA5) begin
            errors++; $display("FAIL alt_rdata got %h exp a5", a_rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dbg_write();
        bit got = 0;
        a_req1 = 1'b1; a_rw1 = 1'b1; a_addr1 = 8'h20; a_wd1 = 8'h3C;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (a_mem_en) begin
                checks++;
                if ({a_mem_rw, a_mem_addr, a_mem_wdata, a_gnt1, a_gnt0} !== {1'b1, 8'h20, 8'h3C, 1'b1, 1'b0}) begin
                    errors++; $display("FAIL dbg_wr_issue rw %b addr %h wdata %h gnt %b%b", a_mem_rw, a_mem_addr, a_mem_wdata, a_gnt0, a_gnt1);
                end
            end
            if (a_ack1) begin
                got = 1; a_req1 = 1'b0;
                checks++;
                if (a_rdata !== 8'hA5) begin
                    errors++; $display("FAIL dbg_wr_rdata got %h exp a5", a_rdata);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL dbg_wr_timeout got no ack1 exp ack1");
        end
        @(negedge clk);
        checks++;
        if (a_ack1 !== 1'b0) begin
            errors++; $display("FAIL dbg_wr_pulse got %b exp 0", a_ack1);
        end
        checks++;
        if (mem_a[8'h20] !== 8'h3C) begin
            errors++; $display("FAIL dbg_wr_mem got %h exp 3c", mem_a[8'h20]);
        end
        got = 0;
        a_req0 = 1'b1; a_rw0 = 1'b0; a_addr0 = 8'h20;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (a_ack0) begin
                got = 1; a_req0 = 1'b0;
                checks++;
                if (a_rdata !== 8'h3C) begin
                    errors++; $display("FAIL readback got %h exp 3c", a_rdata);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL readback_timeout got no ack0 exp ack0");
        end
        @(negedge clk);
    endtask

    task automatic test_lat3();
        preload(1'b1, 8'h44, 8'h5A);
        b_req0 = 1'b1; b_rw0 = 1'b0; b_addr0 = 8'h44;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (b_mem_en !== (c == 1)) begin
                errors++; $display("FAIL lat3_en cycle %0d got %b exp %b", c, b_mem_en, c == 1);
            end
            checks++;
            if (b_ack0 !== (c == 4)) begin
                errors++; $display("FAIL lat3_ack cycle %0d got %b exp %b", c, b_ack0, c == 4);
            end
            if (c <= 3) begin
                checks++;
                if (b_mem_addr !== 8'h44 || b_gnt0 !== 1'b1) begin
                    errors++; $display("FAIL lat3_addr cycle %0d addr %h gnt0 %b exp 44 1", c, b_mem_addr, b_gnt0);
                end
            end
            if (c == 4) begin
                checks++;
                if (b_rdata !== 8'h5A) begin
                    errors++; $display("FAIL lat3_data got %h exp 5a", b_rdata);
                end
                b_req0 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_wait();
        int acks = 0;
        b_req0 = 1'b1; b_rw0 = 1'b0; b_addr0 = 8'h44;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({b_gnt0, b_mem_en, b_ack0} !== 3'b100) begin
            errors++; $display("FAIL rstw_in_wait gnt0 %b en %b ack0 %b exp 1 0 0", b_gnt0, b_mem_en, b_ack0);
        end
        rst_n = 1'b0; b_req0 = 1'b0;
        #1;
        checks++;
        if ({b_gnt0, b_gnt1, b_ack0, b_ack1, b_mem_en, b_mem_rw, b_mem_addr, b_mem_wdata, b_rdata} !== '0) begin
            errors++; $display("FAIL rstw_outputs gnt %b%b ack %b%b en %b addr %h rdata %h exp 0", b_gnt0, b_gnt1, b_ack0, b_ack1, b_mem_en, b_mem_addr, b_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (b_ack0 || b_ack1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL rstw_no_ack got %0d acks exp 0", acks);
        end
        b_req0 = 1'b1; b_req1 = 1'b1; b_addr1 = 8'h44;
        @(negedge clk);
        checks++;
        if ({b_gnt0, b_gnt1, b_mem_en} !== 3'b101) begin
            errors++; $display("FAIL rstw_tie gnt %b%b en %b exp cpu", b_gnt0, b_gnt1, b_mem_en);
        end
        b_req0 = 1'b0; b_req1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_lock();
        logic exp_own [4];
        int   exp_cyc [4];
        logic got_own [4];
        int   got_cyc [4];
        int   n = 0;
        int   cpu_n = 0;
        int   gnt0_gaps = 0;
`ifdef ARB_LOCK_EN
        exp_own = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_cyc = '{1, 3, 5, 8};
`else
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_cyc = '{1, 4, 7, 10};
`endif
        do_reset();
        a_req0 = 1'b1; a_lock0 = 1'b1; a_rw0 = 1'b0; a_addr0 = 8'h01;
        a_req1 = 1'b1; a_rw1 = 1'b0; a_addr1 = 8'h02;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_mem_en && n < 4) begin
                got_own[n] = a_gnt1; got_cyc[n] = c; n++;
            end
            if (c <= 6 && !a_gnt0) gnt0_gaps++;
            if (a_ack0) begin
                cpu_n++;
                if (cpu_n < 3) a_addr0 = 8'(cpu_n + 1);
                else begin a_req0 = 1'b0; a_lock0 = 1'b0; end
            end
            if (a_ack1) a_req1 = 1'b0;
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL lock_count got %0d exp 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_own[i] !== exp_own[i] || got_cyc[i] != exp_cyc[i]) begin
                    errors++; $display("FAIL lock_txn %0d got owner %b cycle %0d exp owner %b cycle %0d", i, got_own[i], got_cyc[i], exp_own[i], exp_cyc[i]);
                end
            end
        end
`ifdef ARB_LOCK_EN
        checks++;
        if (gnt0_gaps != 0) begin
            errors++; $display("FAIL lock_gnt0_continuous got %0d gaps exp 0", gnt0_gaps);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] ref_mem [16];
        bit         pend [2];
        bit         op_rw [2];
        bit         op_lock [2];
        logic [7:0] op_addr [2];
        logic [7:0] op_wd [2];
        bit         active = 0;
        bit         t_own = 0;
        bit         t_rw = 0;
        bit         rr_last = 1;
        bit         in_txn, start, s_own, force_new;
        logic [7:0] t_addr = '0, t_wd = '0, t_rd = '0, exp_rdata = '0;
        int         t_issue = 0, t_done = 0, free_at = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'($urandom);
            preload(1'b0, 8'(i), ref_mem[i]);
        end
        pend = '{0, 0};
        op_lock = '{0, 0};
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            in_txn = active && cyc >= t_issue && cyc <= t_done;
            if (active && cyc == t_done && !t_rw) exp_rdata = t_rd;
            checks++;
            if (a_gnt0 !== (in_txn && !t_own)) begin
                errors++; $display("FAIL rnd_gnt0 cycle %0d got %b exp %b", cyc, a_gnt0, in_txn && !t_own);
            end
            checks++;
            if (a_gnt1 !== (in_txn && t_own)) begin
                errors++; $display("FAIL rnd_gnt1 cycle %0d got %b exp %b", cyc, a_gnt1, in_txn && t_own);
            end
            checks++;
            if (a_mem_en !== (active && cyc == t_issue)) begin
                errors++; $display("FAIL rnd_en cycle %0d got %b exp %b", cyc, a_mem_en, active && cyc == t_issue);
            end
            checks++;
            if ({a_ack1, a_ack0} !== {active && cyc == t_done && t_own, active && cyc == t_done && !t_own}) begin
                errors++; $display("FAIL rnd_ack cycle %0d got %b%b", cyc, a_ack1, a_ack0);
            end
            checks++;
            if (a_rdata !== exp_rdata) begin
                errors++; $display("FAIL rnd_rdata cycle %0d got %h exp %h", cyc, a_rdata, exp_rdata);
            end
            if (active && cyc == t_issue) begin
                checks++;
                if (a_mem_rw !== t_rw || a_mem_addr !== t_addr || (t_rw && a_mem_wdata !== t_wd)) begin
                    errors++; $display("FAIL rnd_bus cycle %0d got rw %b addr %h wd %h exp rw %b addr %h wd %h", cyc, a_mem_rw, a_mem_addr, a_mem_wdata, t_rw, t_addr, t_wd);
                end
            end
            for (int r = 0; r < 2; r++) begin
                force_new = 0;
                if (active && cyc == t_done && t_own == 1'(r)) begin
                    pend[r] = 0;
                    force_new = op_lock[r];
                end
                if (!pend[r] && (force_new || $urandom_range(0, 1) == 0)) begin
                    pend[r]    = 1;
                    op_rw[r]   = 1'($urandom_range(0, 1));
                    op_addr[r] = 8'($urandom_range(0, 15));
                    op_wd[r]   = 8'($urandom);
                    op_lock[r] = ($urandom_range(0, 2) == 0);
                end
            end
            a_req0 = pend[0]; a_rw0 = op_rw[0]; a_addr0 = op_addr[0]; a_wd0 = op_wd[0];
            a_req1 = pend[1]; a_rw1 = op_rw[1]; a_addr1 = op_addr[1]; a_wd1 = op_wd[1];
            a_lock0 = pend[0] && op_lock[0];
            a_lock1 = pend[1] && op_lock[1];
            start = 0; s_own = 0;
            if (active && cyc == t_done) begin
                active = 0;
`ifdef ARB_LOCK_EN
                if (pend[t_own] && op_lock[t_own]) begin start = 1; s_own = t_own; end
`endif
            end else if (!active && cyc >= free_at && (pend[0] || pend[1])) begin
                s_own   = (pend[0] && pend[1]) ? !rr_last : pend[1];
                rr_last = s_own;
                start   = 1;
            end
            if (start) begin
                active  = 1;
                t_own   = s_own;
                t_issue = cyc + 1;
                t_done  = cyc + 2;
                free_at = t_done + 1;
                t_rw    = op_rw[s_own];
                t_addr  = op_addr[s_own];
                t_wd    = op_wd[s_own];
                if (t_rw) ref_mem[t_addr[3:0]] = t_wd;
                else t_rd = ref_mem[t_addr[3:0]];
            end
        end
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_alternate();
        test_dbg_write();
        test_lat3();
        test_reset_wait();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
